// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared types and constants for the HH:MM:SS clock controller
package clock_ctrl_pkg;
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;
    localparam int FLD_SEC   = 0;
    localparam int FLD_MIN   = 1;
    localparam int FLD_HOUR  = 2;
    localparam int TIMEOUT_W = 8;
    function automatic mode_e next_mode(input mode_e m);
        return m == MODE_RUN      ? MODE_SET_HOUR :
               m == MODE_SET_HOUR ? MODE_SET_MIN  :
               m == MODE_SET_MIN  ? MODE_SET_SEC  : MODE_RUN;
    endfunction
endpackage

// File: rtl/clock_blink_gen.sv
// clock_blink_gen: half-period divider toggling a blink phase bit while enabled
module clock_blink_gen #(
    parameter int HALF = 12_500_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic restart,
    output logic phase
);
    localparam int CW = HALF > 1 ? $clog2(HALF) : 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart || !en) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == CW'(HALF - 1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: run/set sequencer for three chained BCD time counters
// Optional field blinking is built only when CLK_BLINK_EN is defined.
module clock_time_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TIMEOUT_S  = 30,
    parameter int BLINK_HALF = 12_500_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_co,
    input  logic       min_co,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hour_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic [2:0] blank
);
    mode_e mode_q, mode_d;
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic sec_inc_d, min_inc_d, hour_inc_d, sec_clr_d;
    logic run, timeout, inc_ok;
    always_comb begin
        run        = mode_q == MODE_RUN;
        timeout    = !run && to_q >= TIMEOUT_W'(TIMEOUT_S);
        inc_ok     = btn_inc && !btn_mode && !timeout;
        mode_d     = timeout ? MODE_RUN : btn_mode ? next_mode(mode_q) : mode_q;
        sec_inc_d  = run && tick_1hz;
        min_inc_d  = run ? sec_co : (mode_q == MODE_SET_MIN && inc_ok);
        hour_inc_d = run ? min_co : (mode_q == MODE_SET_HOUR && inc_ok);
        sec_clr_d  = mode_q == MODE_SET_SEC && inc_ok;
        // any button restarts the inactivity count; only ticks advance it
        to_d = (run || timeout || btn_mode || btn_inc) ? '0 :
               tick_1hz ? to_q + 1'b1 : to_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q   <= MODE_RUN;
            to_q     <= '0;
            sec_inc  <= 1'b0;
            min_inc  <= 1'b0;
            hour_inc <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            to_q     <= to_d;
            sec_inc  <= sec_inc_d;
            min_inc  <= min_inc_d;
            hour_inc <= hour_inc_d;
            sec_clr  <= sec_clr_d;
        end
    end
    assign mode = mode_q;
`ifdef CLK_BLINK_EN
    logic phase;
    clock_blink_gen #(.HALF(BLINK_HALF)) u_blink (
        .clk     (clk),
        .rstn    (rstn),
        .en      (mode_q != MODE_RUN),
        .restart (mode_d != mode_q),
        .phase   (phase)
    );
    always_comb begin
        blank           = 3'b000;
        blank[FLD_HOUR] = phase && mode_q == MODE_SET_HOUR;
        blank[FLD_MIN]  = phase && mode_q == MODE_SET_MIN;
        blank[FLD_SEC]  = phase && mode_q == MODE_SET_SEC;
    end
`else
    assign blank = 3'b000;
`endif
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed vectors feed a scoreboard queue checked by an independent monitor
module tb_clock_time_ctrl;
    logic clk = 1'b0, rstn = 1'b0;
    logic tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, sec_co = 1'b0, min_co = 1'b0;
    logic sec_inc, min_inc, hour_inc, sec_clr;
    logic [1:0] mode;
    logic [2:0] blank;

    clock_time_ctrl #(.TIMEOUT_S(3), .BLINK_HALF(4)) dut (
        .clk(clk), .rstn(rstn), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_co(sec_co), .min_co(min_co), .sec_inc(sec_inc), .min_inc(min_inc),
        .hour_inc(hour_inc), .sec_clr(sec_clr), .mode(mode), .blank(blank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  p;
        logic [1:0]  m;
        logic [2:0]  b;
        logic [2:0]  bm;
        logic [15:0] id;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int vid = 0;

    // inputs {tick,mode,inc,sec_co,min_co}; pulses {sec_inc,min_inc,hour_inc,sec_clr}
    localparam logic [4:0] IDLE = 5'b00000, TK = 5'b10000, MD = 5'b01000, IN = 5'b00100,
                           SC = 5'b00010, MC = 5'b00001;
    localparam logic [3:0] NP = 4'b0000, SI = 4'b1000, MI = 4'b0100, HI = 4'b0010, CL = 4'b0001;

    task automatic drv(input logic [4:0] in, input logic [3:0] p, input logic [1:0] m,
                       input logic [2:0] b, input logic [2:0] bm);
        exp_t e;
        @(negedge clk);
        {tick_1hz, btn_mode, btn_inc, sec_co, min_co} = in;
        vid++;
        e.p = p; e.m = m; e.b = b; e.bm = bm; e.id = vid[15:0];
        q.push_back(e);
    endtask

    task automatic vv(input logic [4:0] in, input logic [3:0] p, input logic [1:0] m);
        drv(in, p, m, 3'b000, 3'b000);
    endtask

    task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        {tick_1hz, btn_mode, btn_inc, sec_co, min_co} = IDLE;
        for (int i = 0; i < 200 && q.size() != 0; i++) #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d vectors left, want 0", q.size());
            q.delete();
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                if ({sec_inc, min_inc, hour_inc, sec_clr} !== e.p || mode !== e.m ||
                    (blank & e.bm) !== (e.b & e.bm)) begin
                    bad++;
                    $display("FAIL vec%0d: got pulses=%b mode=%0d blank=%b, want pulses=%b mode=%0d blank=%b mask=%b",
                             e.id, {sec_inc, min_inc, hour_inc, sec_clr}, mode, blank, e.p, e.m, e.b, e.bm);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", {sec_inc, min_inc, hour_inc, sec_clr, mode, blank}, 9'b0);
        rstn = 1'b1;
        // ticks forwarded in RUN
        repeat (3) begin
            vv(TK, SI, 2'd0);
            vv(IDLE, NP, 2'd0);
        end
        // carries forwarded, btn_inc ignored in RUN
        vv(SC, MI, 2'd0);
        vv(MC, HI, 2'd0);
        vv(IN, NP, 2'd0);
        vv(SC | MC, MI | HI, 2'd0);
        // set walk-through: ticks and carries masked
        vv(MD, NP, 2'd1);
        repeat (2) begin
            vv(IN, HI, 2'd1);
            vv(TK, NP, 2'd1);
        end
        repeat (3) vv(IN, HI, 2'd1);
        vv(SC | MC, NP, 2'd1);
        vv(MD, NP, 2'd2);
        vv(IN, MI, 2'd2);
        vv(MD, NP, 2'd3);
        vv(IN, CL, 2'd3);
        vv(MD, NP, 2'd0);
        // same-cycle events
        vv(TK | MD, SI, 2'd1);
        vv(MD | IN, NP, 2'd2);
        vv(MD, NP, 2'd3);
        vv(MD, NP, 2'd0);
        // timeout after 3 ticks; tick on the return edge is swallowed
        vv(MD, NP, 2'd1);
        vv(MD, NP, 2'd2);
        repeat (3) vv(TK, NP, 2'd2);
        vv(TK, NP, 2'd0);
        vv(TK, SI, 2'd0);
        // btn_inc restarts the timeout
        vv(MD, NP, 2'd1);
        vv(MD, NP, 2'd2);
        vv(TK, NP, 2'd2);
        vv(TK, NP, 2'd2);
        vv(IN, MI, 2'd2);
        vv(TK, NP, 2'd2);
        vv(TK, NP, 2'd2);
        vv(IDLE, NP, 2'd2);
        vv(TK, NP, 2'd2);
        vv(IDLE, NP, 2'd0);
        // asynchronous reset mid-set drops an in-flight pulse
        vv(MD, NP, 2'd1);
        drain();
        chk("pre_reset_mode", {7'b0, mode}, 9'd1);
        @(negedge clk);
        btn_inc = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        chk("async_reset", {sec_inc, min_inc, hour_inc, sec_clr, mode, blank}, 9'b0);
        @(posedge clk);
        #1;
        chk("reset_drops_pulse", {sec_inc, min_inc, hour_inc, sec_clr, mode, blank}, 9'b0);
        btn_inc = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
`ifdef CLK_BLINK_EN
        // blink in SET_MIN / SET_SEC with a 4-cycle half period
        vv(MD, NP, 2'd1);
        drv(MD, NP, 2'd2, 3'b000, 3'b111);
        repeat (3) drv(IDLE, NP, 2'd2, 3'b000, 3'b111);
        repeat (4) drv(IDLE, NP, 2'd2, 3'b010, 3'b111);
        drv(IDLE, NP, 2'd2, 3'b000, 3'b111);
        drv(MD, NP, 2'd3, 3'b000, 3'b111);
        repeat (3) drv(IDLE, NP, 2'd3, 3'b000, 3'b111);
        drv(IDLE, NP, 2'd3, 3'b001, 3'b111);
        drain();
        chk("blank_before_reset", {6'b0, blank}, 9'b001);
        rstn = 1'b0;
        #1;
        chk("blink_async_reset", {7'b0, mode, blank}, 9'b0);
        @(negedge clk);
        rstn = 1'b1;
`endif
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
